// File: rtl/ray_div_dispatch_if.sv
// ---------------------------------------------------------------------------
// ray_div_dispatch_if
// Groups the ray dispatcher's two bus-facing sides into one bundle:
//   - upstream ray handshake : ray_valid_i, ray_data_i, ray_ready_o
//   - divider lane bus       : div_busy_i, div_stall_i, div_start_o,
//                              div_data_o, div_tag_o
// Signal suffixes are as seen from the dispatcher.
// Modports:
//   slave  - the dispatcher (receives rays, drives the divider bus)
//   master - the environment (sources rays, reports divider status)
// ---------------------------------------------------------------------------
interface ray_div_dispatch_if #(
  parameter int unsigned DIV_COUNT = 16,
  parameter int unsigned TAG_SIZE  = 8,
  parameter int unsigned DATA_W    = 96
) ();

  // Upstream payload handshake
  logic                 ray_valid_i;
  logic [DATA_W-1:0]    ray_data_i;
  logic                 ray_ready_o;

  // Divider lanes
  logic [DIV_COUNT-1:0] div_busy_i;
  logic [DIV_COUNT-1:0] div_stall_i;
  logic [DIV_COUNT-1:0] div_start_o;
  logic [DATA_W-1:0]    div_data_o;
  logic [TAG_SIZE-1:0]  div_tag_o;

  modport slave (
    input  ray_valid_i,
    input  ray_data_i,
    output ray_ready_o,
    input  div_busy_i,
    input  div_stall_i,
    output div_start_o,
    output div_data_o,
    output div_tag_o
  );

  modport master (
    output ray_valid_i,
    output ray_data_i,
    input  ray_ready_o,
    output div_busy_i,
    output div_stall_i,
    input  div_start_o,
    input  div_data_o,
    input  div_tag_o
  );

endinterface

// File: rtl/ray_div_dispatch.sv
// ---------------------------------------------------------------------------
// ray_div_dispatch
// Front end of the normalize stage. Accepts one ray payload per valid/ready
// handshake, stamps it with a one-hot tag and issues it to one free divider
// lane chosen round-robin starting after the last granted lane. In-flight
// rays are limited to TAG_SIZE by a credit counter that retire_i returns.
// A flush request stops intake, waits for all credits to come back and then
// restarts the tag sequence at 1.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-high
//   bus           slave modport of ray_div_dispatch_if:
//                   ray_valid_i/ray_data_i/ray_ready_o  upstream handshake
//                   div_busy_i/div_stall_i              per-lane status
//                   div_start_o/div_data_o/div_tag_o    lane issue bus
//   retire_i      in   one ray left the reorder stage (one credit back)
//   flush_i       in   level request: stop accepting, drain, restart tags
//   idle_o        out  FSM in IDLE and nothing outstanding
//   retire_err_o  out  sticky: retire_i seen with nothing outstanding
//
// Optional feature macro: RAY_DISPATCH_STATS_EN
//   When defined, adds stat_issued_o (accept count) and stat_stall_o
//   (cycles with ray_valid_i && !ray_ready_o), both 32-bit saturating.
//
// ray_ready_o is combinational from the current state and inputs so the
// very first ray in IDLE is taken without a bubble.
// ---------------------------------------------------------------------------
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

module ray_div_dispatch #(
  parameter int unsigned DIV_COUNT = 16,
  parameter int unsigned TAG_SIZE  = `TAG_SIZE,
  parameter int unsigned DATA_W    = 96
) (
  input  logic               clk,
  input  logic               reset,
  ray_div_dispatch_if.slave  bus,
  input  logic               retire_i,
  input  logic               flush_i,
  output logic               idle_o,
  output logic               retire_err_o
`ifdef RAY_DISPATCH_STATS_EN
  ,
  output logic [31:0]        stat_issued_o,
  output logic [31:0]        stat_stall_o
`endif
);

  localparam int unsigned LW  = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int unsigned LW1 = LW + 1;
  localparam int unsigned OW  = $clog2(TAG_SIZE + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [OW-1:0]        outstanding_q, outstanding_d;
  logic [TAG_SIZE-1:0]  next_tag_q, next_tag_d;
  logic [LW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [DIV_COUNT-1:0] lane_hold_q;

  logic [DIV_COUNT-1:0] eligible;
  logic [LW-1:0]        grant;
  logic                 grant_vld;
  logic [DIV_COUNT-1:0] grant_oh;
  logic                 ready;
  logic                 accept;
  logic                 retire_ok;

  // (base + off) mod DIV_COUNT, safe for non power-of-two lane counts
  function automatic logic [LW-1:0] lane_add(input logic [LW-1:0] base,
                                             input int unsigned   off);
    logic [LW1-1:0] sum;
    sum = LW1'(base) + LW1'(off);
    if (sum >= LW1'(DIV_COUNT)) begin
      sum = sum - LW1'(DIV_COUNT);
    end
    return LW'(sum);
  endfunction

  // lane_hold masks a lane for the cycle its start is on the bus, before
  // the divider has raised busy
  assign eligible = ~bus.div_busy_i & ~bus.div_stall_i & ~lane_hold_q;

  // Round-robin search starting at rr_ptr
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int unsigned k = 0; k < DIV_COUNT; k++) begin
      if (!grant_vld && eligible[lane_add(rr_ptr_q, k)]) begin
        grant     = lane_add(rr_ptr_q, k);
        grant_vld = 1'b1;
      end
    end
  end

  assign grant_oh = DIV_COUNT'(1) << grant;

  // Intake gate; held low through reset so nothing is taken while resetting
  assign ready = !reset
              && (state_q != ST_DRAIN)
              && !flush_i
              && (outstanding_q < OW'(TAG_SIZE))
              && grant_vld;

  assign bus.ray_ready_o = ready;
  assign accept          = bus.ray_valid_i && ready;
  // A retire with no credit out is an error and must not underflow
  assign retire_ok       = retire_i && (outstanding_q != '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, tag, pointer and credit update
  always_comb begin
    state_d       = state_q;
    next_tag_d    = next_tag_q;
    rr_ptr_d      = rr_ptr_q;
    outstanding_d = outstanding_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.ray_valid_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outstanding_q == '0) begin
          state_d    = ST_IDLE;
          next_tag_d = TAG_SIZE'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Accept never coincides with the DRAIN exit, since ready is low there
    if (accept) begin
      next_tag_d = (next_tag_q << 1) | (next_tag_q >> (TAG_SIZE - 1));
      rr_ptr_d   = (grant == LW'(DIV_COUNT - 1)) ? '0 : grant + LW'(1);
    end

    unique case ({accept, retire_ok})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Datapath registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_q   <= '0;
      next_tag_q      <= TAG_SIZE'(1);
      rr_ptr_q        <= '0;
      lane_hold_q     <= '0;
      bus.div_start_o <= '0;
      bus.div_data_o  <= '0;
      bus.div_tag_o   <= '0;
      idle_o          <= 1'b1;
      retire_err_o    <= 1'b0;
    end else begin
      outstanding_q   <= outstanding_d;
      next_tag_q      <= next_tag_d;
      rr_ptr_q        <= rr_ptr_d;
      lane_hold_q     <= accept ? grant_oh : '0;
      bus.div_start_o <= accept ? grant_oh : '0;
      if (accept) begin
        bus.div_data_o <= bus.ray_data_i;
        bus.div_tag_o  <= next_tag_q;
      end
      idle_o <= (state_d == ST_IDLE) && (outstanding_d == '0);
      if (retire_i && (outstanding_q == '0)) begin
        retire_err_o <= 1'b1;
      end
    end
  end

`ifdef RAY_DISPATCH_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issued_o <= '0;
      stat_stall_o  <= '0;
    end else begin
      if (accept && (stat_issued_o != '1)) begin
        stat_issued_o <= stat_issued_o + 32'd1;
      end
      if (bus.ray_valid_i && !ready && (stat_stall_o != '1)) begin
        stat_stall_o <= stat_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ray_div_dispatch.sv
// ---------------------------------------------------------------------------
// tb_ray_div_dispatch
// Directed bench for ray_div_dispatch (DIV_COUNT=4, TAG_SIZE=8, DATA_W=96).
// Every accepted ray pushes {lane, payload, tag, cycle} to a scoreboard;
// a negedge monitor pops it when the start is due and compares the issue bus.
// ---------------------------------------------------------------------------
module tb_ray_div_dispatch;

  localparam int unsigned DC = 4;
  localparam int unsigned TS = 8;
  localparam int unsigned DW = 96;

  typedef struct {
    int            lane;
    logic [DW-1:0] data;
    logic [TS-1:0] tag;
    int            cyc;
  } exp_t;

  logic clk;
  logic reset;
  logic retire_i;
  logic flush_i;
  logic idle_o;
  logic retire_err_o;
`ifdef RAY_DISPATCH_STATS_EN
  logic [31:0] stat_issued_o;
  logic [31:0] stat_stall_o;
`endif

  ray_div_dispatch_if #(.DIV_COUNT(DC), .TAG_SIZE(TS), .DATA_W(DW)) bus ();

  ray_div_dispatch #(.DIV_COUNT(DC), .TAG_SIZE(TS), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .retire_i     (retire_i),
    .flush_i      (flush_i),
    .idle_o       (idle_o),
    .retire_err_o (retire_err_o)
`ifdef RAY_DISPATCH_STATS_EN
    ,
    .stat_issued_o(stat_issued_o),
    .stat_stall_o (stat_stall_o)
`endif
  );

  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            exp_lane = 0;
  int            bench_rr = 0;
  logic [TS-1:0] model_tag = 8'h01;
  exp_t          sbq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Scoreboard monitor: compare due starts, then record new accepts
  always @(negedge clk) begin
    if (!reset) begin
      logic          due;
      logic [DC-1:0] exp_start;
      exp_t          e;
      due       = (sbq.size() > 0) && (sbq[0].cyc + 1 == cyc);
      exp_start = '0;
      if (due) begin
        exp_start = DC'(1) << sbq[0].lane;
      end
      if (due || (|bus.div_start_o)) begin
        chk("start_lane", 128'(bus.div_start_o), 128'(exp_start));
        if (due) begin
          e = sbq.pop_front();
          chk("start_data", 128'(bus.div_data_o), 128'(e.data));
          chk("start_tag", 128'(bus.div_tag_o), 128'(e.tag));
        end
      end
      if (bus.ray_valid_i && bus.ray_ready_o) begin
        sbq.push_back('{lane: exp_lane, data: bus.ray_data_i, tag: model_tag, cyc: cyc});
        model_tag = {model_tag[TS-2:0], model_tag[TS-1]};
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one ray to the round-robin lane the bench expects and require it taken
  task automatic send(input string name);
    bus.ray_valid_i = 1'b1;
    bus.ray_data_i  = {$urandom(), $urandom(), $urandom()};
    exp_lane        = bench_rr;
    @(negedge clk);
    chk(name, 128'(bus.ray_ready_o), 128'd1);
    bench_rr = (bench_rr + 1) % DC;
    next_cycle();
    bus.ray_valid_i = 1'b0;
  endtask

  initial begin
    int cnt;
    reset           = 1'b1;
    retire_i        = 1'b0;
    flush_i         = 1'b0;
    bus.ray_valid_i = 1'b0;
    bus.ray_data_i  = '0;
    bus.div_busy_i  = '0;
    bus.div_stall_i = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 128'(bus.ray_ready_o), 128'd0);
    chk("rst_start", 128'(bus.div_start_o), 128'd0);
    chk("rst_data", 128'(bus.div_data_o), 128'd0);
    chk("rst_tag", 128'(bus.div_tag_o), 128'd0);
    chk("rst_idle", 128'(idle_o), 128'd1);
    chk("rst_err", 128'(retire_err_o), 128'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Four back-to-back rays: lanes 0..3, tags 01/02/04/08
    for (int i = 0; i < 4; i++) send("b2b_ready");
    repeat (2) next_cycle();

    // Lane 0 busy, lane 1 stalled, rr_ptr=0 -> lane 2
    bus.div_busy_i  = 4'b0001;
    bus.div_stall_i = 4'b0010;
    bench_rr        = 2;
    send("skip_ready");
    bus.div_busy_i  = '0;
    bus.div_stall_i = 4'b1111;
    bus.ray_valid_i = 1'b1;
    @(negedge clk);
    chk("allstall_ready", 128'(bus.ray_ready_o), 128'd0);
    next_cycle();
    @(negedge clk);
    chk("allstall_nostart", 128'(bus.div_start_o), 128'd0);
    next_cycle();
    bus.ray_valid_i = 1'b0;
    bus.div_stall_i = '0;

    // Fill to 8 outstanding, 9th blocked until one retire
    for (int i = 0; i < 3; i++) send("fill_ready");
    bus.ray_valid_i = 1'b1;
    @(negedge clk);
    chk("full_ready", 128'(bus.ray_ready_o), 128'd0);
    next_cycle();
    retire_i = 1'b1;
    @(negedge clk);
    chk("full_ready_retire", 128'(bus.ray_ready_o), 128'd0);
    next_cycle();
    retire_i = 1'b0;
    send("after_retire_ready");
    @(negedge clk);
    chk("wrap_tag", 128'(bus.div_tag_o), 128'h01);
    next_cycle();

    // Down to 3, accept+retire together, then exactly 5 more fit
    retire_i = 1'b1;
    repeat (5) next_cycle();
    send("same_cycle_ready");
    retire_i = 1'b0;
    cnt = 0;
    bus.ray_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.ray_data_i = {$urandom(), $urandom(), $urandom()};
      exp_lane       = bench_rr;
      @(negedge clk);
      if (!bus.ray_ready_o) break;
      bench_rr = (bench_rr + 1) % DC;
      cnt++;
      next_cycle();
    end
    next_cycle();
    bus.ray_valid_i = 1'b0;
    chk("credits_after_same_cycle", 128'(cnt), 128'd5);

    // Return all 8 credits, then one retire too many
    retire_i = 1'b1;
    repeat (8) next_cycle();
    retire_i = 1'b0;
    @(negedge clk);
    chk("no_err_yet", 128'(retire_err_o), 128'd0);
    next_cycle();
    retire_i = 1'b1;
    next_cycle();
    retire_i = 1'b0;
    @(negedge clk);
    chk("retire_err_set", 128'(retire_err_o), 128'd1);
    repeat (3) next_cycle();
    chk("retire_err_sticky", 128'(retire_err_o), 128'd1);

    // Flush with 2 outstanding
    send("flush_pre1");
    send("flush_pre2");
    flush_i         = 1'b1;
    bus.ray_valid_i = 1'b1;
    @(negedge clk);
    chk("flush_ready", 128'(bus.ray_ready_o), 128'd0);
    next_cycle();
    flush_i = 1'b0;
    @(negedge clk);
    chk("drain_ready", 128'(bus.ray_ready_o), 128'd0);
    next_cycle();
    bus.ray_valid_i = 1'b0;
    retire_i        = 1'b1;
    repeat (2) next_cycle();
    retire_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (idle_o) break;
      next_cycle();
    end
    chk("drain_idle", 128'(idle_o), 128'd1);
    next_cycle();
    model_tag = 8'h01;
    send("post_flush_ready");
    @(negedge clk);
    chk("post_flush_tag", 128'(bus.div_tag_o), 128'h01);
    next_cycle();

    // Reset right after an accept discards the pending start
    bus.ray_valid_i = 1'b1;
    bus.ray_data_i  = {$urandom(), $urandom(), $urandom()};
    exp_lane        = bench_rr;
    @(negedge clk);
    chk("pre_rst_ready", 128'(bus.ray_ready_o), 128'd1);
    next_cycle();
    bus.ray_valid_i = 1'b0;
    reset           = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk("midrst_start", 128'(bus.div_start_o), 128'd0);
    next_cycle();
    reset     = 1'b0;
    model_tag = 8'h01;
    bench_rr  = 0;
    @(negedge clk);
    chk("midrst_idle", 128'(idle_o), 128'd1);
    next_cycle();
    send("post_rst_ready");
    @(negedge clk);
    chk("post_rst_tag", 128'(bus.div_tag_o), 128'h01);
    chk("post_rst_lane", 128'(bus.div_start_o), 128'h1);
    repeat (3) next_cycle();
    chk("sb_empty", 128'(sbq.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
